fpu_ss_issue_ctrl: RTL and testbench
====================================

# fpu_ss_issue_ctrl

Issue and writeback scheduler for the FPU subsystem. Sits between the instruction buffer pop port and the FPU and memory datapaths. Tracks pending FP destination registers in a scoreboard and holds back any instruction with a RAW or WAW hazard. Arbitrates the single FP register-file write port between FPU results and memory load responses.

## Interface
- `NUM_FPR`, 32: number of FP registers; scoreboard width.
- `MAX_OUTSTANDING`, 4: maximum number of issued, not yet written-back ops; counter width is `$clog2(MAX_OUTSTANDING+1)`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `instr_valid_i`  in  1  buffer head valid.
- `instr_ready_o`  out  1  pop head; equals issue.
- `use_fpu_i`  in  1  1 = FPU op, 0 = FP load.
- `rs_used_i`  in  3  rs1/rs2/rs3 read-enable mask.
- `rs1_i`, `rs2_i`, `rs3_i`  in  5 each  FP source addresses.
- `rd_i`  in  5  destination address.
- `rd_is_fp_i`  in  1  destination is an FP register.
- `fpu_in_valid_o`  out  1  issue to FPU.
- `fpu_in_ready_i`  in  1  FPU accepts.
- `mem_req_valid_o`  out  1  issue load.
- `mem_req_ready_i`  in  1  memory accepts.
- `fpu_out_valid_i`  in  1  FPU result valid.
- `fpu_out_rd_i`  in  5  FPU result destination.
- `fpu_out_is_fp_i`  in  1  FPU result targets an FP register.
- `fpu_out_ready_o`  out  1  result consumed.
- `mem_rsp_valid_i`  in  1  load data valid.
- `mem_rsp_rd_i`  in  5  load destination.
- `mem_rsp_ready_o`  out  1  load consumed.
- `fpr_we_o`  out  1  FP register-file write enable.
- `fpr_waddr_o`  out  5  write address.
- `wb_sel_o`  out  1  0 = FPU data, 1 = memory data.
- `flush_i`  in  1  drain request.
- `idle_o`  out  1  no outstanding ops and in `RUN`.

## Operation
- Scoreboard `pend_q[NUM_FPR]` has one bit per FP register.
- A hazard exists if any used source has its `pend_q` bit set, or if `rd_is_fp_i` is set and `pend_q[rd_i]` is set.
- The block may issue when all of the following hold: `instr_valid_i`, no hazard, `cnt_q < MAX_OUTSTANDING`, and state is `RUN`.
- `fpu_in_valid_o` and `mem_req_valid_o` equal the issue condition gated by `use_fpu_i` and `~use_fpu_i` respectively.
- Issue fires on valid & ready. `instr_ready_o` is high only in the fire cycle.
- On fire:
  - `cnt_q` is incremented.
  - If the destination is FP, `pend_q[rd_i]` is set. Loads always have an FP destination.
- Writeback arbitration: memory response has fixed priority.
  - `mem_rsp_ready_o` = 1 whenever `mem_rsp_valid_i` is high.
  - `fpu_out_ready_o` = ~`mem_rsp_valid_i`, or 1 when the FPU result is non-FP (integer results leave on the response channel and do not use the port).
- Each consumed result or response decrements `cnt_q` and clears `pend_q[rd]` when it writes an FP register.
- `fpr_we_o` is high for each consumed FP-destination result or response; `wb_sel_o` is driven to match.
- Simultaneous issue and retirement in one cycle give a net counter change: +1, 0 or −1. Two retirements in one cycle (memory FP writeback plus FPU non-FP result) give −2.
- If a clear and a set of the same scoreboard bit happen in one cycle, the set wins.
- States:
  - `RUN`: normal. On `flush_i` → `DRAIN`.
  - `DRAIN`: no issue. When `cnt_q == 0` → `RUN`.
- `flush_i` held in `RUN` with `cnt_q == 0` → `DRAIN` for exactly one cycle.

## Timing
- Issue decision is combinational from the buffer head and `pend_q`. Zero-cycle issue latency.
- Scoreboard and counter update on the clock edge after the handshake.
- Default behaviour: a register cleared by writeback in cycle N unblocks its consumer at cycle N+1.
- Reset values: `pend_q` = 0, `cnt_q` = 0, state = `RUN`.
- Output reset values:
  - All valid/ready/write-enable outputs are 0, except `fpu_out_ready_o` = 1 and `mem_rsp_ready_o` = 0.
  - `idle_o` = 1.
  - `fpr_waddr_o` = 0 and `wb_sel_o` = 0.
- Reset asserted mid-operation discards all pending bits. Results arriving after reset are accepted and ignored: no decrement below 0, which saturates.
- `cnt_q` never exceeds `MAX_OUTSTANDING`. The full condition blocks issue but never blocks retirement.

## Configuration
- `FPU_SS_WB_BYPASS_EN` defined: hazard check uses `pend_q` masked by this cycle's FP writeback clear. A consumer issues in the same cycle its source is written back. Issuing also checks `cnt_q - retire < MAX_OUTSTANDING`.
- Undefined: hazard check uses registered `pend_q` only. Adds one cycle of writeback-to-issue latency.

## Structure
- `fpu_ss_pkg`:
  - `fpu_ss_issue_state_e` (`RUN`, `DRAIN`).
  - `FPR_ADDR_W` = 5.
  - `wb_sel_e` (`WB_FPU`, `WB_MEM`).
- Sub-module `fpu_ss_scoreboard`: set/clear ports and a three-source plus destination hazard lookup. Instantiated once.

## Test plan
- Back-to-back independent FPU ops f1 = f2 + f3, then f4 = f5 + f6 → both issue in consecutive cycles; `cnt_q` reaches 2.
- RAW: f1 = f2 + f3, then f4 = f1 + f5 → second op held until f1 writeback. Issues 1 cycle after writeback without the bypass, same cycle with `FPU_SS_WB_BYPASS_EN`.
- Load to f7 and FPU result to f8 valid in the same cycle → memory write first (`wb_sel_o` = 1, addr 7). FPU write the next cycle (addr 8); `fpu_out_ready_o` low during the first cycle.
- Issue 4 ops with no retirement → 5th held with `instr_ready_o` = 0. One retirement → 5th issues the next cycle.
- `flush_i` with 3 outstanding → no issue until 3 retirements, then `RUN`; `idle_o` = 1.
- `rst_ni` low with 2 outstanding and `pend_q[1]` set → all outputs at reset values; a pending instruction reading f1 issues immediately after reset release.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// fpu_ss_pkg
//
// Shared types and constants for the FPU subsystem issue/writeback logic.
//
// Contents:
//   FPR_ADDR_W            width of an FP register address
//   fpu_ss_issue_state_e  issue controller state (RUN, DRAIN)
//   wb_sel_e              register-file write data source (WB_FPU, WB_MEM)
//   fpr_onehot()          decode an FP register address into a one-hot mask
package fpu_ss_pkg;

    localparam int FPR_ADDR_W = 5;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fpu_ss_issue_state_e;

    typedef enum logic {
        WB_FPU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

    // One-hot decode of a 5-bit register address into a 32-entry mask.
    function automatic logic [31:0] fpr_onehot(input logic [FPR_ADDR_W-1:0] addr);
        logic [31:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/fpu_ss_scoreboard.sv
// fpu_ss_scoreboard
//
// One pending bit per FP register. A bit is set when an instruction writing
// that register issues and cleared when its result is written back. The
// lookup reports a hazard for the instruction at the buffer head.
//
// Optional feature: FPU_SS_WB_BYPASS_EN. When defined, the lookup sees the
// pending bits with this cycle's writeback already removed, so a consumer
// can issue in the same cycle its source is written.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   set_i, set_addr_i        mark a register pending (issue)
//   clr_i, clr_addr_i        release a register (FP writeback)
//   rs_used_i                rs1/rs2/rs3 read-enable mask
//   rs1_i, rs2_i, rs3_i      source register addresses
//   rd_check_i, rd_i         destination check enable and address (WAW)
//   hazard_o                 head instruction must wait
module fpu_ss_scoreboard
    import fpu_ss_pkg::*;
#(
    parameter int NUM_FPR = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_i,
    input  logic [FPR_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_i,
    input  logic [FPR_ADDR_W-1:0] clr_addr_i,
    input  logic [2:0]            rs_used_i,
    input  logic [FPR_ADDR_W-1:0] rs1_i,
    input  logic [FPR_ADDR_W-1:0] rs2_i,
    input  logic [FPR_ADDR_W-1:0] rs3_i,
    input  logic                  rd_check_i,
    input  logic [FPR_ADDR_W-1:0] rd_i,
    output logic                  hazard_o
);

    logic [NUM_FPR-1:0] pend_q;
    logic [NUM_FPR-1:0] pend_d;
    logic [NUM_FPR-1:0] set_mask;
    logic [NUM_FPR-1:0] clr_mask;
    logic [NUM_FPR-1:0] look_pend;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask = NUM_FPR'(fpr_onehot(set_addr_i));
        if (clr_i) clr_mask = NUM_FPR'(fpr_onehot(clr_addr_i));
        // Set is applied after clear so a same-cycle set of the same bit wins.
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

`ifdef FPU_SS_WB_BYPASS_EN
    assign look_pend = pend_q & ~clr_mask;
`else
    assign look_pend = pend_q;
`endif

    assign hazard_o = (rs_used_i[0] & look_pend[rs1_i])
                    | (rs_used_i[1] & look_pend[rs2_i])
                    | (rs_used_i[2] & look_pend[rs3_i])
                    | (rd_check_i   & look_pend[rd_i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/fpu_ss_issue_ctrl.sv
// fpu_ss_issue_ctrl
//
// Issue and writeback scheduler for the FPU subsystem. Holds back the
// instruction buffer head on RAW/WAW hazards against pending FP destinations,
// limits the number of in-flight operations, and arbitrates the single FP
// register-file write port between memory responses (priority) and FPU
// results.
//
// Optional feature: FPU_SS_WB_BYPASS_EN. When defined, this cycle's FP
// writeback and retirements are taken into account by the issue decision,
// removing one cycle of writeback-to-issue latency.
//
// Handshakes: every channel is valid/ready; a transfer happens in a cycle
// where both are high. Outputs valid signals never depend on the matching
// ready input.
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   instr_valid_i / instr_ready_o       buffer head; ready pulses on issue
//   use_fpu_i, rs_used_i, rs1_i..rs3_i,
//   rd_i, rd_is_fp_i                    head instruction fields
//   fpu_in_valid_o / fpu_in_ready_i     issue to the FPU
//   mem_req_valid_o / mem_req_ready_i   issue an FP load
//   fpu_out_valid_i/_rd_i/_is_fp_i,
//   fpu_out_ready_o                     FPU result channel
//   mem_rsp_valid_i/_rd_i, mem_rsp_ready_o  load response channel
//   fpr_we_o, fpr_waddr_o, wb_sel_o     FP register-file write port
//   flush_i                             drain request
//   idle_o                              nothing outstanding and in RUN
module fpu_ss_issue_ctrl
    import fpu_ss_pkg::*;
#(
    parameter int NUM_FPR         = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic                  use_fpu_i,
    input  logic [2:0]            rs_used_i,
    input  logic [FPR_ADDR_W-1:0] rs1_i,
    input  logic [FPR_ADDR_W-1:0] rs2_i,
    input  logic [FPR_ADDR_W-1:0] rs3_i,
    input  logic [FPR_ADDR_W-1:0] rd_i,
    input  logic                  rd_is_fp_i,
    output logic                  fpu_in_valid_o,
    input  logic                  fpu_in_ready_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    input  logic                  fpu_out_valid_i,
    input  logic [FPR_ADDR_W-1:0] fpu_out_rd_i,
    input  logic                  fpu_out_is_fp_i,
    output logic                  fpu_out_ready_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [FPR_ADDR_W-1:0] mem_rsp_rd_i,
    output logic                  mem_rsp_ready_o,
    output logic                  fpr_we_o,
    output logic [FPR_ADDR_W-1:0] fpr_waddr_o,
    output logic                  wb_sel_o,
    input  logic                  flush_i,
    output logic                  idle_o
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    fpu_ss_issue_state_e   state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      cnt_sub;
    logic [CNT_W-1:0]      retire_cnt;

    logic                  mem_fire;
    logic                  fpu_fire;
    logic                  wb_we;
    logic [FPR_ADDR_W-1:0] wb_addr;
    wb_sel_e               wb_sel;

    logic                  dest_fp;
    logic                  hazard;
    logic                  room;
    logic                  can_issue;
    logic                  issue_fire;

    // ------------------------------------------------------------------
    // Writeback arbitration. Memory responses are always taken; an FPU
    // result with an FP destination yields to them, while integer results
    // never need the port and are always taken. Everything is held off
    // while reset is asserted so the outputs sit at their reset values.
    // ------------------------------------------------------------------
    assign mem_rsp_ready_o = rst_ni & mem_rsp_valid_i;
    assign fpu_out_ready_o = ~rst_ni | ~mem_rsp_valid_i | ~fpu_out_is_fp_i;

    assign mem_fire = rst_ni & mem_rsp_valid_i;
    assign fpu_fire = rst_ni & fpu_out_valid_i & (~mem_rsp_valid_i | ~fpu_out_is_fp_i);

    always_comb begin
        wb_we   = 1'b0;
        wb_addr = '0;
        wb_sel  = WB_FPU;
        if (mem_fire) begin
            wb_we   = 1'b1;
            wb_addr = mem_rsp_rd_i;
            wb_sel  = WB_MEM;
        end else if (fpu_fire && fpu_out_is_fp_i) begin
            wb_we   = 1'b1;
            wb_addr = fpu_out_rd_i;
        end
    end

    assign fpr_we_o    = wb_we;
    assign fpr_waddr_o = wb_addr;
    assign wb_sel_o    = wb_sel;

    // Up to two ops retire per cycle (memory FP write + FPU integer result).
    assign retire_cnt = CNT_W'(mem_fire) + CNT_W'(fpu_fire);
    // Stray results after reset must not wrap the counter below zero.
    assign cnt_sub    = (cnt_q > retire_cnt) ? cnt_q - retire_cnt : '0;

    // ------------------------------------------------------------------
    // Issue decision
    // ------------------------------------------------------------------
    // Loads always write an FP register, whatever rd_is_fp_i says.
    assign dest_fp = rd_is_fp_i | ~use_fpu_i;

    fpu_ss_scoreboard #(
        .NUM_FPR (NUM_FPR)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (issue_fire & dest_fp),
        .set_addr_i (rd_i),
        .clr_i      (wb_we),
        .clr_addr_i (wb_addr),
        .rs_used_i  (rs_used_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rs3_i      (rs3_i),
        .rd_check_i (dest_fp),
        .rd_i       (rd_i),
        .hazard_o   (hazard)
    );

`ifdef FPU_SS_WB_BYPASS_EN
    assign room = cnt_sub < MAX_CNT;
`else
    assign room = cnt_q < MAX_CNT;
`endif

    assign can_issue       = rst_ni & instr_valid_i & ~hazard & room & (state_q == RUN);
    assign fpu_in_valid_o  = can_issue & use_fpu_i;
    assign mem_req_valid_o = can_issue & ~use_fpu_i;
    assign issue_fire      = (fpu_in_valid_o & fpu_in_ready_i)
                           | (mem_req_valid_o & mem_req_ready_i);
    assign instr_ready_o   = issue_fire;

    // Retirements are removed before the issue is added, so the result
    // never exceeds MAX_OUTSTANDING and an op issued alongside a stray
    // retirement is still counted.
    assign cnt_d = cnt_sub + CNT_W'(issue_fire);

    // ------------------------------------------------------------------
    // State and outstanding counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                RUN:     if (flush_i) state_q <= DRAIN;
                DRAIN:   if (cnt_q == '0) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign idle_o = (cnt_q == '0) & (state_q == RUN);

endmodule

// File: tb/tb_fpu_ss_issue_ctrl.sv
// tb_fpu_ss_issue_ctrl
//
// Bench for fpu_ss_issue_ctrl: directed scenarios followed by randomized
// traffic, all checked against a register-level reference model kept here.
// Honours FPU_SS_WB_BYPASS_EN the same way as the design.
module tb_fpu_ss_issue_ctrl;

    localparam int MAX_OUT = 4;
`ifdef FPU_SS_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk_i = 1'b0;
    logic       rst_ni;
    always #5 clk_i = ~clk_i;

    logic       instr_valid_i, instr_ready_o, use_fpu_i, rd_is_fp_i;
    logic [2:0] rs_used_i;
    logic [4:0] rs1_i, rs2_i, rs3_i, rd_i;
    logic       fpu_in_valid_o, fpu_in_ready_i, mem_req_valid_o, mem_req_ready_i;
    logic       fpu_out_valid_i, fpu_out_is_fp_i, fpu_out_ready_o;
    logic [4:0] fpu_out_rd_i, mem_rsp_rd_i, fpr_waddr_o;
    logic       mem_rsp_valid_i, mem_rsp_ready_o, fpr_we_o, wb_sel_o;
    logic       flush_i, idle_o;

    fpu_ss_issue_ctrl #(
        .NUM_FPR         (32),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .use_fpu_i       (use_fpu_i),
        .rs_used_i       (rs_used_i),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .rs3_i           (rs3_i),
        .rd_i            (rd_i),
        .rd_is_fp_i      (rd_is_fp_i),
        .fpu_in_valid_o  (fpu_in_valid_o),
        .fpu_in_ready_i  (fpu_in_ready_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_rd_i    (fpu_out_rd_i),
        .fpu_out_is_fp_i (fpu_out_is_fp_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_rd_i    (mem_rsp_rd_i),
        .mem_rsp_ready_o (mem_rsp_ready_o),
        .fpr_we_o        (fpr_we_o),
        .fpr_waddr_o     (fpr_waddr_o),
        .wb_sel_o        (wb_sel_o),
        .flush_i         (flush_i),
        .idle_o          (idle_o)
    );

    // ---------------- scoreboard / counters ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [5:0] exp_q[$];      // expected {wb_sel, waddr} of each FP write

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit [31:0] m_pend;   // registers waiting for a write
    int        m_cnt;    // ops issued and not yet retired
    bit        m_drain;  // flush seen, waiting for m_cnt to reach zero

    // Environment: ops in flight, returned in order per unit.
    int fq_rd[$];
    bit fq_fp[$];
    int mq_rd[$];

    // One cycle: inputs already driven just after the falling edge.
    task automatic step();
        bit        mfire, ffire, wb, sel, dfp, haz, room, can, fire;
        int        waddr, retire, cnt_eff;
        bit [31:0] look;
        #1;
        if (!rst_ni) begin
            m_pend  = '0;
            m_cnt   = 0;
            m_drain = 1'b0;
        end
        mfire  = (rst_ni === 1'b1) && mem_rsp_valid_i;
        ffire  = (rst_ni === 1'b1) && fpu_out_valid_i && (!mem_rsp_valid_i || !fpu_out_is_fp_i);
        wb     = mfire || (ffire && fpu_out_is_fp_i);
        waddr  = mfire ? int'(mem_rsp_rd_i) : (wb ? int'(fpu_out_rd_i) : 0);
        sel    = mfire;
        retire = int'(mfire) + int'(ffire);
        look   = m_pend;
        cnt_eff = m_cnt;
        if (BYP) begin
            if (wb) look[waddr] = 1'b0;
            cnt_eff = (m_cnt > retire) ? m_cnt - retire : 0;
        end
        dfp  = rd_is_fp_i || !use_fpu_i;
        haz  = (rs_used_i[0] && look[rs1_i]) || (rs_used_i[1] && look[rs2_i]) ||
               (rs_used_i[2] && look[rs3_i]) || (dfp && look[rd_i]);
        room = cnt_eff < MAX_OUT;
        can  = (rst_ni === 1'b1) && instr_valid_i && !haz && room && !m_drain;
        fire = can && (use_fpu_i ? fpu_in_ready_i : mem_req_ready_i);

        check("fpu_in_valid", fpu_in_valid_o, can && use_fpu_i);
        check("mem_req_valid", mem_req_valid_o, can && !use_fpu_i);
        check("instr_ready", instr_ready_o, fire);
        check("mem_rsp_ready", mem_rsp_ready_o, mfire);
        check("fpu_out_ready", fpu_out_ready_o, !(rst_ni === 1'b1) || !mem_rsp_valid_i || !fpu_out_is_fp_i);
        check("idle", idle_o, (m_cnt == 0) && !m_drain);
        check("fpr_we", fpr_we_o, wb);
        if (wb) exp_q.push_back({sel, 5'(waddr)});
        if (fpr_we_o) begin
            if (exp_q.size() > 0) check("wb_port", {wb_sel_o, fpr_waddr_o}, exp_q.pop_front());
            else check("wb_extra", fpr_we_o, 1'b0);
        end else if (wb) begin
            void'(exp_q.pop_front());
        end

        // environment bookkeeping
        if (ffire && fq_rd.size() > 0) begin
            void'(fq_rd.pop_front());
            void'(fq_fp.pop_front());
        end
        if (mfire && mq_rd.size() > 0) void'(mq_rd.pop_front());
        if (fire) begin
            if (use_fpu_i) begin
                fq_rd.push_back(int'(rd_i));
                fq_fp.push_back(rd_is_fp_i);
            end else begin
                mq_rd.push_back(int'(rd_i));
            end
        end

        // model next state
        if (rst_ni === 1'b1) begin
            if (m_drain) begin
                if (m_cnt == 0) m_drain = 1'b0;
            end else if (flush_i) begin
                m_drain = 1'b1;
            end
            if (wb) m_pend[waddr] = 1'b0;
            if (fire && dfp) m_pend[rd_i] = 1'b1;
            m_cnt = ((m_cnt > retire) ? m_cnt - retire : 0) + int'(fire);
        end
        @(negedge clk_i);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_results(input int pct);
        fpu_out_valid_i = 1'b0; fpu_out_rd_i = '0; fpu_out_is_fp_i = 1'b0;
        mem_rsp_valid_i = 1'b0; mem_rsp_rd_i = '0;
        if (fq_rd.size() > 0 && int'($urandom_range(99)) < pct) begin
            fpu_out_valid_i = 1'b1;
            fpu_out_rd_i    = 5'(fq_rd[0]);
            fpu_out_is_fp_i = fq_fp[0];
        end
        if (mq_rd.size() > 0 && int'($urandom_range(99)) < pct) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_rd_i    = 5'(mq_rd[0]);
        end
    endtask

    task automatic set_instr(input bit v, input bit fpu, input logic [2:0] used,
                             input int s1, input int s2, input int s3, input int d, input bit dfp);
        instr_valid_i = v;    use_fpu_i  = fpu;  rs_used_i = used;
        rs1_i = 5'(s1); rs2_i = 5'(s2); rs3_i = 5'(s3); rd_i = 5'(d);
        rd_is_fp_i = dfp;
    endtask

    task automatic idle_inputs();
        set_instr(1'b0, 1'b1, 3'b000, 0, 0, 0, 0, 1'b1);
        fpu_in_ready_i = 1'b1; mem_req_ready_i = 1'b1; flush_i = 1'b0;
        drive_results(0);
    endtask

    task automatic issue_op(input bit fpu, input logic [2:0] used, input int s1, input int s2,
                            input int d, input string tag);
        set_instr(1'b1, fpu, used, s1, s2, 0, d, 1'b1);
        drive_results(0);
        #1 check(tag, instr_ready_o, 1'b1);
        step();
        instr_valid_i = 1'b0;
    endtask

    task automatic drain_all();
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        for (int i = 0; i < 60 && (fq_rd.size() > 0 || mq_rd.size() > 0 || m_cnt != 0 || m_drain); i++) begin
            drive_results(100);
            step();
        end
        drive_results(0);
        check("drained_idle", idle_o, 1'b1);
    endtask

    task automatic check_reset(input string p);
        check({p, "_instr_ready"}, instr_ready_o, 1'b0);
        check({p, "_fpu_in_valid"}, fpu_in_valid_o, 1'b0);
        check({p, "_mem_req_valid"}, mem_req_valid_o, 1'b0);
        check({p, "_fpu_out_ready"}, fpu_out_ready_o, 1'b1);
        check({p, "_mem_rsp_ready"}, mem_rsp_ready_o, 1'b0);
        check({p, "_fpr_we"}, fpr_we_o, 1'b0);
        check({p, "_fpr_waddr"}, fpr_waddr_o, 5'd0);
        check({p, "_wb_sel"}, wb_sel_o, 1'b0);
        check({p, "_idle"}, idle_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        #1 check_reset("por");
        step();
        rst_ni = 1'b1;

        // Back-to-back independent ops: f1 = f2 + f3, f4 = f5 + f6.
        issue_op(1'b1, 3'b011, 2, 3, 1, "bb_first");
        issue_op(1'b1, 3'b011, 5, 6, 4, "bb_second");
        #1 check("bb_busy", idle_o, 1'b0);
        drain_all();

        // RAW: f1 = f2 + f3 then f4 = f1 + f5.
        issue_op(1'b1, 3'b011, 2, 3, 1, "raw_prod");
        set_instr(1'b1, 1'b1, 3'b011, 1, 5, 0, 4, 1'b1);
        drive_results(0);
        #1 check("raw_hold", instr_ready_o, 1'b0);
        step();
        drive_results(100);                      // writeback of f1
        #1 check("raw_wb_cycle", instr_ready_o, BYP);
        step();
        drive_results(0);                        // with bypass f4 is now pending (WAW)
        #1 check("raw_next", instr_ready_o, !BYP);
        step();
        drain_all();

        // Load to f7 and FPU result to f8 in the same cycle.
        issue_op(1'b0, 3'b000, 0, 0, 7, "ld_f7");
        issue_op(1'b1, 3'b000, 0, 0, 8, "op_f8");
        drive_results(100);
        #1;
        check("arb_sel_mem", wb_sel_o, 1'b1);
        check("arb_addr7", fpr_waddr_o, 5'd7);
        check("arb_fpu_stall", fpu_out_ready_o, 1'b0);
        step();
        drive_results(100);
        #1;
        check("arb_sel_fpu", wb_sel_o, 1'b0);
        check("arb_addr8", fpr_waddr_o, 5'd8);
        check("arb_we2", fpr_we_o, 1'b1);
        step();
        drain_all();

        // Outstanding limit.
        for (int k = 0; k < MAX_OUT; k++) issue_op(1'b1, 3'b000, 0, 0, 10 + k, "full_fill");
        set_instr(1'b1, 1'b1, 3'b000, 0, 0, 0, 14, 1'b1);
        drive_results(0);
        #1 check("full_hold", instr_ready_o, 1'b0);
        step();
        drive_results(100);                      // one FPU retirement
        #1 check("full_retire_cycle", instr_ready_o, BYP);
        step();
        drive_results(0);
        #1 check("full_next", instr_ready_o, !BYP);
        step();
        drain_all();

        // Flush with three outstanding.
        for (int k = 0; k < 3; k++) issue_op(1'b1, 3'b000, 0, 0, 16 + k, "flush_fill");
        flush_i = 1'b1;
        drive_results(0);
        #1 check("flush_busy", idle_o, 1'b0);
        step();
        flush_i = 1'b0;
        set_instr(1'b1, 1'b1, 3'b000, 0, 0, 0, 20, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_results(100);
            #1 check("drain_hold_retire", instr_ready_o, 1'b0);
            step();
        end
        drive_results(0);
        #1;
        check("drain_hold_zero", instr_ready_o, 1'b0);
        check("drain_not_idle", idle_o, 1'b0);
        step();
        #1;
        check("drain_back_idle", idle_o, 1'b1);
        check("drain_back_issue", instr_ready_o, 1'b1);
        step();
        drain_all();

        // Reset with two outstanding and f1 pending.
        issue_op(1'b1, 3'b000, 0, 0, 1, "rst_op1");
        issue_op(1'b0, 3'b000, 0, 0, 2, "rst_ld2");
        set_instr(1'b1, 1'b1, 3'b001, 1, 0, 0, 9, 1'b1);
        drive_results(0);
        #1 check("rst_pre_hold", instr_ready_o, 1'b0);
        step();
        rst_ni = 1'b0;
        fq_rd.delete(); fq_fp.delete(); mq_rd.delete();
        #1 check_reset("rst_mid");
        step();
        rst_ni = 1'b1;
        #1 check("rst_release_issue", instr_ready_o, 1'b1);
        step();
        drain_all();

        // Stray load response with nothing outstanding: counter must hold at 0.
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rd_i    = 5'd5;
        #1 check("stray_rsp_ready", mem_rsp_ready_o, 1'b1);
        step();
        drive_results(0);
        #1 check("stray_idle", idle_o, 1'b1);
        step();

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 800; c++) begin
            rst_ni          = (c == 400) ? 1'b0 : 1'b1;
            instr_valid_i   = ($urandom_range(3) != 0);
            use_fpu_i       = 1'($urandom_range(1));
            rs_used_i       = 3'($urandom_range(7));
            rs1_i           = 5'($urandom_range(7));
            rs2_i           = 5'($urandom_range(7));
            rs3_i           = 5'($urandom_range(7));
            rd_i            = 5'($urandom_range(7));
            rd_is_fp_i      = use_fpu_i ? ($urandom_range(3) != 0) : 1'b1;
            fpu_in_ready_i  = ($urandom_range(3) != 0);
            mem_req_ready_i = ($urandom_range(3) != 0);
            flush_i         = ($urandom_range(39) == 0);
            drive_results(40);
            step();
        end
        rst_ni = 1'b1;
        drain_all();
        check("wb_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
